countdown_timer: RTL
====================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter WIDTH, default 8, bit width of the count and load value (2..32).
REQ-002 Parameter START, default 5, count and reload value after reset (< 2**WIDTH).
REQ-003 Parameter PRESCALE, default 1, number of clock cycles per decrement tick (1..65535).
REQ-004 One clock and a synchronous, active-high reset; the ports are named clock and reset.
REQ-005 clock  input  1  rising-edge system clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  single-cycle request to begin or restart the countdown.
REQ-008 pause  input  1  level input; while high, the count and the prescaler are frozen in RUN.
REQ-009 load  input  1  single-cycle request to capture load_value.
REQ-010 load_value  input  WIDTH  new count and reload value.
REQ-011 auto_reload  input  1  level input; when high, expiry reloads the count and keeps running.
REQ-012 count  output  WIDTH  current count value, registered.
REQ-013 running  output  1  high in state RUN.
REQ-014 paused  output  1  high in state PAUSE.
REQ-015 expired  output  1  high in state EXPIRED.
REQ-016 done  output  1  one-cycle registered pulse at each expiry.

Function
REQ-017 The FSM shall have four states: IDLE, RUN, PAUSE and EXPIRED; all outputs are registered.
REQ-018 load shall be accepted in any state: count and reload_reg take load_value, the state goes to IDLE, the prescaler clears and done stays 0.
REQ-019 load shall have priority over start and pause in the same cycle.
REQ-020 start in IDLE shall enter RUN with the prescaler cleared and count unchanged.
REQ-021 start in EXPIRED shall set count to reload_reg and enter RUN with the prescaler cleared.
REQ-022 start in RUN or PAUSE shall be ignored.
REQ-023 In RUN, the prescaler shall count 0..PRESCALE-1 and wrap; a tick occurs on the cycle it equals PRESCALE-1.
REQ-024 With start sampled at edge k, the first decrement shall occur at edge k+PRESCALE.
REQ-025 On a tick with count greater than 1, count shall decrement by 1.
REQ-026 On a tick with count equal to 1 and auto_reload=0, count shall go to 0, the state to EXPIRED, and done shall pulse in the same edge.
REQ-027 On a tick with count equal to 1, auto_reload=1 and reload_reg not 0, count shall take reload_reg, the state shall stay RUN, and done shall pulse.
REQ-028 When RUN is entered with count equal to 0, the next edge shall go to EXPIRED with a done pulse and no decrement; count shall never wrap below 0.
REQ-029 With auto_reload=1 and reload_reg equal to 0, behaviour shall be identical to auto_reload=0.
REQ-030 pause high in RUN shall enter PAUSE at the next edge; the prescaler and count are frozen.
REQ-031 pause low in PAUSE shall return to RUN and resume the prescaler from its held value.
REQ-032 pause shall be ignored in IDLE and EXPIRED.
REQ-033 In IDLE and EXPIRED, count shall hold.
REQ-034 done shall be high for exactly one cycle per expiry and low at all other times.

Reset
REQ-035 On reset=1 at a rising edge, the block shall set count=START, reload_reg=START, state IDLE, prescaler=0, and done, running, paused and expired to 0.
REQ-036 reset shall take priority over every other input, including mid-count and during PAUSE.
REQ-037 There shall be no asynchronous reset path.

Structure
REQ-038 The state encodings (IDLE=0, RUN=1, PAUSE=2, EXPIRED=3) shall be defined in the shared package countdown_pkg.
REQ-039 The prescaler shall be a sub-module tick_divider (parameter PRESCALE; ports clock, reset, clear, enable, tick).
REQ-040 With PRESCALE=1, tick_divider shall hold tick high whenever enable is high.

Verification
REQ-041 Bench: reset, then start with PRESCALE=1 -> count 5,4,3,2,1,0 on successive edges; done pulses once, with count=0; expired=1.
REQ-042 Bench: PRESCALE=4, load 3, start -> count decrements every 4 cycles; done fires 12 cycles after start was sampled.
REQ-043 Bench: load 2, auto_reload=1, start -> sequence 2,1,2,1,... with a done pulse on each 1->2 transition; running stays 1.
REQ-044 Bench: pause for 7 cycles mid-count at count=3 -> count and prescaler frozen; resume completes with the total latency extended by exactly 7 cycles.
REQ-045 Bench: load 0 then start -> EXPIRED and a done pulse on the next edge; count stays 0.
REQ-046 Bench: reset asserted at count=2 in RUN, and load+start asserted in the same cycle -> count=START and IDLE; then load wins over start (IDLE, count=load_value).

Source files
------------

// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM state encodings and sizing helpers.
package countdown_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_PAUSE   = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    // Width of a counter that must hold 0..n-1 (never narrower than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler: counts enabled cycles 0..PRESCALE-1 and flags the last one as a tick.
module tick_divider
    import countdown_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned      CW   = cnt_width(PRESCALE);
    localparam logic [CW-1:0]    LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_phase;

    // With PRESCALE=1 the phase is pinned at 0 == LAST, so tick follows enable.
    assign tick = enable && (r_phase == LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_phase <= '0;
        end else if (enable) begin
            r_phase <= (r_phase == LAST) ? '0 : r_phase + CW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Prescaled countdown timer with load, start, pause and optional auto-reload.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned START    = 5,
    parameter int unsigned PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             paused,
    output logic             expired,
    output logic             done
);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_done;
    logic             r_running;
    logic             r_paused;
    logic             r_expired;

    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_done_nxt;
    logic             w_clear;
    logic             w_enable;
    logic             w_tick;

    // PAUSE with pause released resumes on the same edge, so a pause of N
    // cycles stretches the countdown by exactly N cycles.
    assign w_enable = ((r_state == ST_RUN) || (r_state == ST_PAUSE)) && !pause;

    tick_divider #(.PRESCALE(PRESCALE)) u_div (
        .clock  (clock),
        .reset  (reset),
        .clear  (w_clear),
        .enable (w_enable),
        .tick   (w_tick)
    );

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_done_nxt  = 1'b0;
        w_clear     = 1'b0;
        if (load) begin
            w_state_nxt = ST_IDLE;
            w_count_nxt = load_value;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                        w_clear     = 1'b1;
                    end
                end
                ST_EXPIRED: begin
                    if (start) begin
                        w_state_nxt = ST_RUN;
                        w_count_nxt = r_reload;
                        w_clear     = 1'b1;
                    end
                end
                default: begin
                    if (pause) begin
                        w_state_nxt = ST_PAUSE;
                    end else begin
                        w_state_nxt = ST_RUN;
                        if (r_count == '0) begin
                            w_state_nxt = ST_EXPIRED;
                            w_done_nxt  = 1'b1;
                        end else if (w_tick) begin
                            if (r_count != WIDTH'(1)) begin
                                w_count_nxt = r_count - WIDTH'(1);
                            end else if (auto_reload && (r_reload != '0)) begin
                                w_count_nxt = r_reload;
                                w_done_nxt  = 1'b1;
                            end else begin
                                w_count_nxt = '0;
                                w_state_nxt = ST_EXPIRED;
                                w_done_nxt  = 1'b1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they align with count.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= WIDTH'(START);
            r_reload  <= WIDTH'(START);
            r_done    <= 1'b0;
            r_running <= 1'b0;
            r_paused  <= 1'b0;
            r_expired <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_count   <= w_count_nxt;
            if (load) begin
                r_reload <= load_value;
            end
            r_done    <= w_done_nxt;
            r_running <= (w_state_nxt == ST_RUN);
            r_paused  <= (w_state_nxt == ST_PAUSE);
            r_expired <= (w_state_nxt == ST_EXPIRED);
        end
    end

    assign count   = r_count;
    assign running = r_running;
    assign paused  = r_paused;
    assign expired = r_expired;
    assign done    = r_done;

endmodule
